// File: rtl/xor_packet_collector_pkg.sv
// Shared sizing for the EC-engine collector: default packet width and group size (matches tree_xor).
// Count fields are derived from the group size, never overridden.
package xor_packet_collector_pkg;

    localparam int DEF_PACKET_LENGTH = 64;
    localparam int DEF_INPUT_NUM     = 12;

    // Width needed to hold a group count of 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/xor_packet_collector_if.sv
// Serial packet input plus grouped parallel output of the collector.
// master = producer/consumer side, slave = collector side.
interface xor_packet_collector_if
    import xor_packet_collector_pkg::*;
#(
    parameter int PACKET_LENGTH = DEF_PACKET_LENGTH,
    parameter int INPUT_NUM     = DEF_INPUT_NUM
);
    localparam int CNT_W = cnt_width(INPUT_NUM);

    logic                     in_valid;
    logic                     in_ready;
    logic [PACKET_LENGTH-1:0] in_packet;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [PACKET_LENGTH-1:0] packets_arr [0:INPUT_NUM-1];
    logic [CNT_W-1:0]         out_count;

    modport master (
        output in_valid, in_packet, in_last, out_ready,
        input  in_ready, out_valid, packets_arr, out_count
    );

    modport slave (
        input  in_valid, in_packet, in_last, out_ready,
        output in_ready, out_valid, packets_arr, out_count
    );
endinterface

// File: rtl/xor_packet_collector_packet_bank.sv
// One ping-pong bank: packet slots, group count and full flag; output zero-masked beyond count or when empty.
// Latency: writes/close/release visible the cycle after the edge; never stalls itself, the owner gates writes.
module packet_bank
    import xor_packet_collector_pkg::*;
#(
    parameter int PACKET_LENGTH = DEF_PACKET_LENGTH,
    parameter int INPUT_NUM     = DEF_INPUT_NUM,
    parameter int CNT_W         = cnt_width(INPUT_NUM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [CNT_W-1:0]         wr_idx,
    input  logic [PACKET_LENGTH-1:0] wr_dat,
    input  logic                     close,
    input  logic [CNT_W-1:0]         close_count,
    input  logic                     rel,
    output logic                     full,
    output logic [CNT_W-1:0]         count_out,
    output logic [PACKET_LENGTH-1:0] arr_out [0:INPUT_NUM-1]
);
    logic [PACKET_LENGTH-1:0] slot [0:INPUT_NUM-1];
    logic [CNT_W-1:0]         count;

    // Slot data is unreset; stale contents are hidden by the count mask.
    always_ff @(posedge clk) begin
        for (int i = 0; i < INPUT_NUM; i++) begin
            if (wr_en && wr_idx == CNT_W'(i))
                slot[i] <= wr_dat;
        end
    end

    // close and rel never hit the same bank in one cycle: close needs !full, rel needs full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            count <= '0;
        end else if (close) begin
            full  <= 1'b1;
            count <= close_count;
        end else if (rel) begin
            full  <= 1'b0;
        end
    end

    always_comb begin
        count_out = full ? count : '0;
        for (int i = 0; i < INPUT_NUM; i++)
            arr_out[i] = (full && CNT_W'(i) < count) ? slot[i] : '0;
    end
endmodule

// File: rtl/xor_packet_collector.sv
// Groups a serial packet stream into sets of up to INPUT_NUM for tree_xor via a ping-pong double buffer.
// Group visible the cycle after its closing accept; in_ready drops only while both banks hold groups.
module xor_packet_collector
    import xor_packet_collector_pkg::*;
#(
    parameter int PACKET_LENGTH = DEF_PACKET_LENGTH,
    parameter int INPUT_NUM     = DEF_INPUT_NUM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xor_packet_collector_if.slave bus
);
    localparam int CNT_W = cnt_width(INPUT_NUM);

    logic                     wr_bank, rd_bank;
    logic [CNT_W-1:0]         wr_cnt;
    logic                     full0, full1;
    logic [CNT_W-1:0]         cnt0, cnt1;
    logic [PACKET_LENGTH-1:0] arr0 [0:INPUT_NUM-1];
    logic [PACKET_LENGTH-1:0] arr1 [0:INPUT_NUM-1];
    logic                     accept, close_grp, rel;
    logic [CNT_W-1:0]         next_cnt;

    // Ready depends on registered state only, so upstream sees no loop through in_valid.
    assign bus.in_ready  = wr_bank ? !full1 : !full0;
    assign bus.out_valid = rd_bank ? full1 : full0;

    assign accept    = bus.in_valid & bus.in_ready;
    assign close_grp = accept & (bus.in_last | (wr_cnt == CNT_W'(INPUT_NUM - 1)));
    assign rel       = bus.out_valid & bus.out_ready;
    assign next_cnt  = wr_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            if (close_grp) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else if (accept) begin
                wr_cnt  <= next_cnt;
            end
            if (rel)
                rd_bank <= ~rd_bank;
        end
    end

    packet_bank #(.PACKET_LENGTH(PACKET_LENGTH), .INPUT_NUM(INPUT_NUM), .CNT_W(CNT_W)) u_bank0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (accept & ~wr_bank),
        .wr_idx     (wr_cnt),
        .wr_dat     (bus.in_packet),
        .close      (close_grp & ~wr_bank),
        .close_count(next_cnt),
        .rel        (rel & ~rd_bank),
        .full       (full0),
        .count_out  (cnt0),
        .arr_out    (arr0)
    );

    packet_bank #(.PACKET_LENGTH(PACKET_LENGTH), .INPUT_NUM(INPUT_NUM), .CNT_W(CNT_W)) u_bank1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (accept & wr_bank),
        .wr_idx     (wr_cnt),
        .wr_dat     (bus.in_packet),
        .close      (close_grp & wr_bank),
        .close_count(next_cnt),
        .rel        (rel & rd_bank),
        .full       (full1),
        .count_out  (cnt1),
        .arr_out    (arr1)
    );

    // Banks already zero their outputs when empty, so a plain select is enough.
    always_comb begin
        bus.out_count = rd_bank ? cnt1 : cnt0;
        for (int i = 0; i < INPUT_NUM; i++)
            bus.packets_arr[i] = rd_bank ? arr1[i] : arr0[i];
    end
endmodule

// File: tb/tb_xor_packet_collector.sv
// Directed bench for xor_packet_collector with PACKET_LENGTH=8, INPUT_NUM=4.
module tb_xor_packet_collector;
    localparam int PL = 8;
    localparam int IN = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    xor_packet_collector_if #(.PACKET_LENGTH(PL), .INPUT_NUM(IN)) bus ();

    xor_packet_collector #(.PACKET_LENGTH(PL), .INPUT_NUM(IN)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] arr_word();
        return {bus.packets_arr[0], bus.packets_arr[1], bus.packets_arr[2], bus.packets_arr[3]};
    endfunction

    // Stand-in for the downstream tree_xor reduction.
    function automatic logic [7:0] arr_xor();
        return bus.packets_arr[0] ^ bus.packets_arr[1] ^ bus.packets_arr[2] ^ bus.packets_arr[3];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] pkt, input logic last);
        bus.in_valid  = 1'b1;
        bus.in_packet = pkt;
        bus.in_last   = last;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] exp_arr;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_packet = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_count", 32'(bus.out_count), 32'h0);
        chk("rst_arr", arr_word(), 32'h0);
        #3 rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Full group
        bus.out_ready = 1'b1;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h04, 1'b0);
        chk("full_not_yet_valid", 32'(bus.out_valid), 32'h0);
        send(8'h08, 1'b0);
        chk("full_out_valid", 32'(bus.out_valid), 32'h1);
        chk("full_count", 32'(bus.out_count), 32'h4);
        chk("full_arr", arr_word(), 32'h01020408);
        chk("full_xor", 32'(arr_xor()), 32'h0F);
        tick();
        chk("full_released", 32'(bus.out_valid), 32'h0);
        chk("full_released_arr", arr_word(), 32'h0);

        // Short group closed by in_last
        send(8'hAA, 1'b0);
        send(8'h55, 1'b1);
        chk("short_out_valid", 32'(bus.out_valid), 32'h1);
        chk("short_count", 32'(bus.out_count), 32'h2);
        chk("short_arr", arr_word(), 32'hAA550000);
        chk("short_xor", 32'(arr_xor()), 32'hFF);
        tick();
        chk("short_released", 32'(bus.out_valid), 32'h0);

        // Backpressure: 8 packets with the consumer stalled
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 7)
                chk("bp_ready_before_8th", 32'(bus.in_ready), 32'h1);
            bus.in_packet = 8'h10 + 8'(k);
            tick();
        end
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
        chk("bp_g1_arr", arr_word(), 32'h10111213);
        chk("bp_g1_count", 32'(bus.out_count), 32'h4);
        bus.in_packet = 8'h18;
        tick();
        chk("bp_g1_stable_arr", arr_word(), 32'h10111213);
        chk("bp_g1_stable_valid", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        chk("bp_ready_low_in_release_cycle", 32'(bus.in_ready), 32'h0);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_g2_valid", 32'(bus.out_valid), 32'h1);
        chk("bp_g2_arr", arr_word(), 32'h14151617);
        chk("bp_g2_count", 32'(bus.out_count), 32'h4);
        chk("bp_in_ready_back", 32'(bus.in_ready), 32'h1);
        tick();
        chk("bp_g2_released", 32'(bus.out_valid), 32'h0);

        // Streaming 12 packets with in_valid held high
        bus.in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("stream_in_ready", 32'(bus.in_ready), 32'h1);
            bus.in_packet = 8'h20 + 8'(k);
            tick();
            chk("stream_out_valid", 32'(bus.out_valid), (k % 4 == 3) ? 32'h1 : 32'h0);
            if (k % 4 == 3) begin
                b = 8'h20 + 8'(k - 3);
                exp_arr = {b, b + 8'd1, b + 8'd2, b + 8'd3};
                chk("stream_arr", arr_word(), exp_arr);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        chk("stream_drained", 32'(bus.out_valid), 32'h0);

        // Close of one bank on the same edge the other is released
        bus.out_ready = 1'b0;
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        send(8'h33, 1'b0);
        send(8'h34, 1'b0);
        chk("sim_held_arr", arr_word(), 32'h31323334);
        send(8'h41, 1'b0);
        bus.out_ready = 1'b1;
        send(8'h42, 1'b1);
        chk("sim_out_valid", 32'(bus.out_valid), 32'h1);
        chk("sim_arr", arr_word(), 32'h41420000);
        chk("sim_count", 32'(bus.out_count), 32'h2);
        chk("sim_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk("sim_released", 32'(bus.out_valid), 32'h0);

        // Reset with one group held and another half-filled
        bus.out_ready = 1'b0;
        send(8'h51, 1'b0);
        send(8'h52, 1'b0);
        send(8'h53, 1'b0);
        send(8'h54, 1'b0);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        chk("mid_held_valid", 32'(bus.out_valid), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_count", 32'(bus.out_count), 32'h0);
        chk("mid_rst_arr", arr_word(), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("mid_rel_in_ready", 32'(bus.in_ready), 32'h1);
        chk("mid_rel_valid", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 1'b1;
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        send(8'h73, 1'b0);
        send(8'h74, 1'b1);
        chk("mid_new_count", 32'(bus.out_count), 32'h4);
        chk("mid_new_arr", arr_word(), 32'h71727374);
        tick();
        chk("mid_new_released", 32'(bus.out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/xor_packet_collector.md
Name: xor_packet_collector

Overview:
- Stage directly upstream of tree_xor in the EC engine.
- Accepts a serial stream of (already GF-scaled) packets over a valid/ready handshake and groups them into sets of up to INPUT_NUM.
- Presents each complete group as a parallel packet array that tree_xor reduces to one parity packet.
- Ping-pong double buffer: one group fills while the previous one is held for the consumer, giving sustained one-packet-per-cycle input throughput.

Parameters:
- PACKET_LENGTH, from global_parameters.v: width of one packet in bits.
- INPUT_NUM, 12: maximum packets per group; equals the tree_xor INPUT_NUM. Legal range is 2 or more.
- CNT_W, $clog2(INPUT_NUM+1): width of the count fields (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_packet is valid.
- in_ready  out  1  collector can accept a packet this cycle.
- in_packet  in  PACKET_LENGTH  packet data.
- in_last  in  1  this accepted packet closes the group early.
- out_valid  out  1  a complete group is presented.
- out_ready  in  1  consumer takes the group this cycle.
- packets_arr  out  PACKET_LENGTH x INPUT_NUM  unpacked array [0:INPUT_NUM-1]; connects to tree_xor packets_arr.
- out_count  out  CNT_W  number of valid packets in the presented group, 1..INPUT_NUM.

Behaviour:
- State: two banks (bank0, bank1), each holding INPUT_NUM packet registers, a count register and a full flag. Also wr_bank (1 bit), rd_bank (1 bit) and wr_cnt (CNT_W bits).
- Reset (async, rst_n=0):
  - wr_bank=0, rd_bank=0, wr_cnt=0, both full flags=0, both counts=0.
  - Outputs: in_ready=1 once rst_n is released, out_valid=0, out_count=0, packets_arr all zero.
  - Packet data registers need not reset; they are masked at the output.
- Handshakes:
  - in_ready = !full[wr_bank]. This is combinational from registers only, never from in_valid.
  - Accept occurs when in_valid & in_ready.
  - out_valid = full[rd_bank].
  - Release occurs when out_valid & out_ready.
- On accept:
  - The bank[wr_bank] slot at index wr_cnt is written with in_packet.
  - If wr_cnt==INPUT_NUM-1 or in_last=1, the group closes:
    - full[wr_bank]<=1
    - count[wr_bank]<=wr_cnt+1
    - wr_cnt<=0
    - wr_bank toggles.
  - Otherwise wr_cnt<=wr_cnt+1.
- On release: full[rd_bank]<=0 and rd_bank toggles.
- Latency: a group closed by the accept at edge N has out_valid=1 in the cycle after edge N. There is no combinational path from the input port to the output port.
- Output masking:
  - packets_arr[i] = bank[rd_bank].slot[i] when i < count[rd_bank]; otherwise all zeros.
  - Zero is the XOR identity, so short groups reduce correctly in tree_xor.
  - When out_valid=0, packets_arr is all zeros and out_count=0.
- Flow-control boundaries:
  - Close and release in the same cycle always target different banks, and both take effect.
  - When both banks are full, in_ready=0. A release in that cycle re-asserts in_ready on the next cycle, not in the same cycle.
- Input stability: packets_arr and out_count must stay stable while out_valid=1 and out_ready=0.
- in_last has meaning only on an accepted beat. Empty groups cannot be formed.
- in_last on the INPUT_NUM-th packet is identical to a normal full close.
- Reset mid-group or mid-hold discards all partial and held groups. No output is produced for them.

Decomposition:
- global_parameters.v holds PACKET_LENGTH and the default INPUT_NUM shared with tree_xor; CNT_W stays local.
- One sub-module, packet_bank, is natural. It holds:
  - INPUT_NUM slot registers with a write enable and write index;
  - the count and full registers with close and release inputs;
  - the masked array output.
- xor_packet_collector instantiates packet_bank twice and owns wr_bank, rd_bank, wr_cnt and the handshake logic.

Test Plan:
Bench settings: PACKET_LENGTH=8, INPUT_NUM=4.
- Full group: send 0x01,0x02,0x04,0x08 back-to-back with out_ready=1 -> out_valid rises the cycle after the 4th accept; packets_arr={01,02,04,08}; out_count=4; tree_xor output 0x0F.
- Short group: send 0xAA,0x55 with in_last on 0x55 -> out_count=2, packets_arr={AA,55,00,00}, XOR result 0xFF.
- Backpressure: hold out_ready=0 and stream 8 packets continuously -> in_ready drops after the 8th accept; the first group is held stable. Raise out_ready -> group 1 is released, group 2 is presented, and in_ready returns the following cycle with no data loss.
- Streaming: out_ready=1 and 12 consecutive packets with in_valid stuck at 1 -> in_ready never drops; three groups are output with correct contents, in order.
- Simultaneous close and release: close bank1 in the same cycle bank0 is released -> both flags update, out_valid stays 1, and packets_arr switches to bank1 contents.
- Reset mid-operation: pull rst_n low after 2 of 4 packets while another group is held -> out_valid=0 and in_ready=1 immediately after release. The next 4 packets form a clean group with out_count=4.
